uart_bus_arbiter: RTL and testbench
===================================

# uart_bus_arbiter

Two-master arbiter that shares the single valid/ready slave port of the UART peripheral between requesters, for example the CPU data port and a debug/boot loader. It grants one master at a time with round-robin fairness and holds the grant for one full transaction. If the UART never completes a transaction, a watchdog terminates it with an error word and counts the event.

## Interface

Parameters:
- TIMEOUT, 1024 — cycles a granted transaction may wait for u_ready before forced termination; legal range 2..65535.
- ERR_RDATA, 32'hFFFF_FFFF — read data returned to the master on a timed-out transaction.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- m0_valid  input  1  master 0 request.
- m0_ready  output  1  master 0 completion strobe.
- m0_addr  input  32  master 0 address.
- m0_wdata  input  32  master 0 write data.
- m0_wstrb  input  4  master 0 byte strobes; 0 = read.
- m0_rdata  output  32  master 0 read data.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata — same as master 0, for master 1.
- u_valid  output  1  request to UART slave.
- u_ready  input  1  UART slave completion.
- u_addr  output  32  forwarded address.
- u_wdata  output  32  forwarded write data.
- u_wstrb  output  4  forwarded strobes.
- u_rdata  input  32  UART read data.
- timeout_count  output  8  saturating count of timed-out transactions.

## Operation

- States:
  - IDLE: no grant.
  - BUSY: grant g in {0,1}.
  - TERM: timeout termination for grant g.
- IDLE:
  - u_valid=0, both m*_ready=0.
  - If any m*_valid is sampled high, register grant and go to BUSY.
  - Single requester: that master is granted.
  - Both requesting: the master other than `last` is granted.
  - On grant, `last` <= granted index.
- BUSY:
  - u_valid = mg_valid.
  - u_addr/u_wdata/u_wstrb = master g fields.
  - mg_ready = u_valid & u_ready, combinational pass-through.
  - mg_rdata = u_rdata.
  - On u_valid & u_ready: go to IDLE; clear wait counter.
  - If mg_valid drops before completion (master abort): go to IDLE, no ready issued, counter cleared.
  - Otherwise the wait counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without u_ready: go to TIMEOUT termination.
- TIMEOUT termination:
  - Lasts exactly one cycle: u_valid=0, mg_ready=1, mg_rdata=ERR_RDATA.
  - timeout_count increments, saturating at 255.
  - Next state IDLE.
- Non-granted master:
  - ready=0, rdata=0.
  - Its valid may stay high indefinitely and is served at the next arbitration.
- When not in BUSY, u_addr, u_wdata and u_wstrb are driven 0.
- Round-robin guarantee: under continuous dual requests, grants alternate 0,1,0,1…

## Timing

- Reset (resetn=0 at a rising edge):
  - state=IDLE, `last`=1 (master 0 wins the first tie), wait counter=0, timeout_count=0.
  - u_valid=0, m0_ready=m1_ready=0, rdata outputs 0.
  - Reset mid-transaction abandons it silently; no ready is issued.
- Arbitration latency: valid sampled high at the end of cycle N gives u_valid high in cycle N+1.
- Completion:
  - u_ready in cycle K gives mg_ready in the same cycle K.
  - IDLE in cycle K+1; next grant at earliest BUSY in K+2.
  - Minimum spacing between two granted transactions is therefore 1 idle cycle.
- Timeout: with u_ready never asserted, u_valid is high for exactly TIMEOUT cycles; TIMEOUT termination follows in the next cycle.
- u_ready arriving while not in BUSY is ignored.
- A master must hold valid and fields stable until its ready; the arbiter does not latch the fields.

## Test plan

- Single read: m0_valid with addr 0x4 and slave ready on its 2nd u_valid cycle returning 0x41 -> u_valid high cycles 1-2, m0_ready pulse in cycle 2, m0_rdata=0x41, m1_ready stays 0.
- Tie after reset: m0 and m1 assert valid in the same cycle -> m0 granted first, m1 granted 1 idle cycle after m0 completes.
- Fairness: both masters hold valid for 6 transactions with a fixed 1-cycle slave -> grant order 0,1,0,1,0,1, and each u_addr matches the granted master.
- Timeout: TIMEOUT=8, u_ready tied 0, m1 read -> u_valid high 8 cycles, then m1_ready=1 with m1_rdata=0xFFFF_FFFF and u_valid=0; timeout_count=1. 300 timeouts leave timeout_count=255.
- Abort and reset: m0 drops valid mid-BUSY -> IDLE next cycle, no ready. resetn=0 mid-BUSY -> all outputs 0 next cycle, the following tie is granted to m0.
- Write forwarding: m1 writes 0x5A with wstrb 0x1 to addr 0x8 -> u_wdata=0x5A, u_wstrb=0x1, u_addr=0x8 while granted, all driven 0 in IDLE.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter in front of the UART valid/ready slave port.
// Holds the grant for one transaction and force-terminates it with ERR_RDATA if u_ready never comes.
module uart_bus_arbiter #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        u_valid,
  input  logic        u_ready,
  output logic [31:0] u_addr,
  output logic [31:0] u_wdata,
  output logic [3:0]  u_wstrb,
  input  logic [31:0] u_rdata,
  output logic [7:0]  timeout_count
);

  // Handshake: a transfer completes in the cycle where u_valid & u_ready are both high;
  // that same cycle raises the granted master's ready. Masters hold valid and fields until ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TERM = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        grant;
  logic        last;
  logic [15:0] wait_cnt;
  logic        sel_valid;
  logic        next_grant;

  assign sel_valid  = grant ? m1_valid : m0_valid;
  // On a tie the master that did not win last time gets the bus.
  assign next_grant = (m0_valid && m1_valid) ? ~last : m1_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last          <= 1'b1;
      wait_cnt      <= 16'd0;
      timeout_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant    <= next_grant;
            last     <= next_grant;
            wait_cnt <= 16'd0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!sel_valid || u_ready) begin
            state    <= IDLE;
            wait_cnt <= 16'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= TERM;
            wait_cnt <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        TERM: begin
          state <= IDLE;
          if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    u_valid  = 1'b0;
    u_addr   = 32'd0;
    u_wdata  = 32'd0;
    u_wstrb  = 4'd0;
    m0_ready = 1'b0;
    m0_rdata = 32'd0;
    m1_ready = 1'b0;
    m1_rdata = 32'd0;
    case (state)
      BUSY: begin
        u_valid = sel_valid;
        if (grant) begin
          u_addr   = m1_addr;
          u_wdata  = m1_wdata;
          u_wstrb  = m1_wstrb;
          m1_ready = sel_valid & u_ready;
          m1_rdata = u_rdata;
        end else begin
          u_addr   = m0_addr;
          u_wdata  = m0_wdata;
          u_wstrb  = m0_wstrb;
          m0_ready = sel_valid & u_ready;
          m0_rdata = u_rdata;
        end
      end
      TERM: begin
        if (grant) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: a transaction-level reference model checked
// against every output on every cycle, plus hand-computed expectations per scenario.
module tb_uart_bus_arbiter;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0, u_ready = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, u_rdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, u_valid;
  logic [31:0] m0_rdata, m1_rdata, u_addr, u_wdata;
  logic [3:0]  u_wstrb;
  logic [7:0]  timeout_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  uart_bus_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .u_valid(u_valid), .u_ready(u_ready), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_wstrb(u_wstrb), .u_rdata(u_rdata), .timeout_count(timeout_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: who owns the bus, how long it has waited, how many timeouts so far
  localparam int P_FREE = 0, P_OWNED = 1, P_KILL = 2;
  int   phase = P_FREE;
  int   owner = 0;
  int   prev_winner = 1;
  int   waited = 0;
  int   kills = 0;
  bit   model_on = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      phase = P_FREE; prev_winner = 1; waited = 0; kills = 0; model_on = 1'b1;
    end else if (model_on) begin
      if (phase == P_KILL) begin
        phase = P_FREE;
        if (kills < 255) kills = kills + 1;
      end else if (phase == P_OWNED) begin
        if (!(owner == 1 ? m1_valid : m0_valid) || u_ready) phase = P_FREE;
        else if (waited == TO - 1) phase = P_KILL;
        else waited = waited + 1;
      end else if (m0_valid || m1_valid) begin
        if (m0_valid && m1_valid) owner = 1 - prev_winner;
        else owner = m1_valid ? 1 : 0;
        prev_winner = owner;
        waited = 0;
        phase = P_OWNED;
      end
    end
  end

  function automatic logic [142:0] model_out();
    logic uv, r0, r1;
    logic [31:0] ua, uw, d0, d1;
    logic [3:0] us;
    uv = 0; r0 = 0; r1 = 0; ua = 0; uw = 0; d0 = 0; d1 = 0; us = 0;
    if (phase == P_OWNED && owner == 0) begin
      uv = m0_valid; ua = m0_addr; uw = m0_wdata; us = m0_wstrb; r0 = uv & u_ready; d0 = u_rdata;
    end else if (phase == P_OWNED) begin
      uv = m1_valid; ua = m1_addr; uw = m1_wdata; us = m1_wstrb; r1 = uv & u_ready; d1 = u_rdata;
    end else if (phase == P_KILL && owner == 0) begin
      r0 = 1; d0 = ERR;
    end else if (phase == P_KILL) begin
      r1 = 1; d1 = ERR;
    end
    return {uv, ua, uw, us, r0, d0, r1, d1, 8'(kills)};
  endfunction

  // every-cycle compare against the model
  always @(negedge clk) begin
    logic [142:0] act, exp;
    if (model_on) begin
      exp = model_out();
      act = {u_valid, u_addr, u_wdata, u_wstrb, m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_count};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got %h expected %h", $time, act, exp);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // which: 0 = m0_ready, 1 = m1_ready, 2 = u_valid; returns at the negedge where it is seen
  task automatic wait_for(input int which, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && m0_ready) || (which == 1 && m1_ready) || (which == 2 && u_valid)) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stimulus
    bit ok;
    int cnt;
    step(); step();
    resetn = 1'b1;

    // single read, slave ready on the 2nd u_valid cycle
    step(); m0_valid = 1; m0_addr = 32'h4;
    @(negedge clk);
    check("reset_uvalid", 32'(u_valid), 32'd0);
    check("reset_tcount", 32'(timeout_count), 32'd0);
    step(); @(negedge clk);
    check("rd_uvalid_c1", 32'(u_valid), 32'd1);
    check("rd_uaddr", u_addr, 32'h4);
    check("rd_m0ready_c1", 32'(m0_ready), 32'd0);
    step(); u_ready = 1; u_rdata = 32'h41; @(negedge clk);
    check("rd_m0ready_c2", 32'(m0_ready), 32'd1);
    check("rd_m0rdata", m0_rdata, 32'h41);
    check("rd_m1ready", 32'(m1_ready), 32'd0);
    step(); m0_valid = 0; u_ready = 0; u_rdata = 0; @(negedge clk);
    check("rd_idle_uvalid", 32'(u_valid), 32'd0);

    // master abort
    step(); m0_valid = 1; m0_addr = 32'h30;
    step(); @(negedge clk);
    check("abort_busy", 32'(u_valid), 32'd1);
    step(); m0_valid = 0; @(negedge clk);
    check("abort_uvalid", 32'(u_valid), 32'd0);
    check("abort_ready", 32'(m0_ready), 32'd0);
    step(); @(negedge clk);
    check("abort_idle", 32'(u_valid), 32'd0);

    // reset mid-transaction, then tie goes to m0, m1 one idle cycle later
    step(); m0_valid = 1; m0_addr = 32'h40;
    step(); @(negedge clk);
    check("rst_busy", 32'(u_valid), 32'd1);
    step(); resetn = 0;
    step(); resetn = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20; @(negedge clk);
    check("rst_uvalid", 32'(u_valid), 32'd0);
    check("rst_m0ready", 32'(m0_ready), 32'd0);
    check("rst_uaddr", u_addr, 32'd0);
    step(); u_ready = 1; @(negedge clk);
    check("tie_first_addr", u_addr, 32'h10);
    check("tie_m0ready", 32'(m0_ready), 32'd1);
    step(); m0_valid = 0; u_ready = 0; @(negedge clk);
    check("tie_gap", 32'(u_valid), 32'd0);
    step(); @(negedge clk);
    check("tie_second_addr", u_addr, 32'h20);
    step(); u_ready = 1; @(negedge clk);
    check("tie_m1ready", 32'(m1_ready), 32'd1);
    step(); m1_valid = 0; u_ready = 0;

    // fairness under continuous dual requests
    step(); m0_valid = 1; m0_addr = 32'h100; m1_valid = 1; m1_addr = 32'h200;
    u_ready = 1; u_rdata = 32'h77;
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2) == 0 ? 32'h100 : 32'h200);
    for (int i = 0; i < 6; i++) begin
      wait_for(2, 4, ok);
      check("fair_grant_seen", 32'(ok), 32'd1);
      if (!ok) break;
      check("fair_order", u_addr, exp_q.pop_front());
    end
    step(); m0_valid = 0; m1_valid = 0; u_ready = 0; u_rdata = 0;

    // timeout on an m1 read
    step(); m1_valid = 1; m1_addr = 32'hC;
    cnt = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_valid) cnt++;
      if (m1_ready) begin ok = 1; break; end
    end
    check("to_ready_seen", 32'(ok), 32'd1);
    check("to_uvalid_cycles", 32'(cnt), 32'd8);
    check("to_rdata", m1_rdata, ERR);
    check("to_uvalid_term", 32'(u_valid), 32'd0);
    step(); m1_valid = 0; @(negedge clk);
    check("to_count1", 32'(timeout_count), 32'd1);

    // write forwarding from m1, fields masked while idle
    step(); m1_valid = 1; m1_addr = 32'h8; m1_wdata = 32'h5A; m1_wstrb = 4'h1;
    step(); @(negedge clk);
    check("wr_uaddr", u_addr, 32'h8);
    check("wr_uwdata", u_wdata, 32'h5A);
    check("wr_uwstrb", 32'(u_wstrb), 32'h1);
    step(); u_ready = 1; @(negedge clk);
    check("wr_m1ready", 32'(m1_ready), 32'd1);
    step(); m1_valid = 0; u_ready = 0; @(negedge clk);
    check("wr_idle_addr", u_addr, 32'd0);
    check("wr_idle_wdata", u_wdata, 32'd0);
    check("wr_idle_wstrb", 32'(u_wstrb), 32'd0);

    // counter saturation: 300 more timeouts
    step(); m1_valid = 1; m1_addr = 32'hC; m1_wstrb = 4'h0;
    for (int i = 0; i < 300; i++) begin
      wait_for(1, 20, ok);
      if (!ok) begin
        check("sat_ready_seen", 32'(ok), 32'd1);
        break;
      end
    end
    step(); m1_valid = 0; @(negedge clk);
    check("sat_count", 32'(timeout_count), 32'd255);

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
